// File: rtl/line_render_sequencer_pkg.sv
// rtl/line_render_sequencer_pkg.sv - shared state encoding, register map and stage order
package line_render_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1   = 3'd1,
        ST_L2   = 3'd2,
        ST_SPR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_OVR_CNT = 2'd1;
    localparam logic [1:0] REG_EN_MASK = 2'd2;

    // Bit i of the latched enable mask gates STAGE_ORDER[i].
    localparam state_t STAGE_ORDER [0:2] = '{ST_L1, ST_L2, ST_SPR};

endpackage

// File: rtl/sat_counter8.sv
// rtl/sat_counter8.sv - 8-bit saturating counter with synchronous clear and increment
module sat_counter8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (inc && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/line_render_sequencer.sv
// rtl/line_render_sequencer.sv - per-line layer1/layer2/sprite render sequencing with overrun reporting
module line_render_sequencer
    import line_render_sequencer_pkg::*;
#(
    parameter int unsigned LAST_LINE = 479
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] regs_addr,
    input  logic [7:0] regs_wrdata,
    input  logic       regs_write,
    output logic [7:0] regs_rddata,
    input  logic [8:0] display_line_idx,
    input  logic       display_start_of_line,
    input  logic       display_start_of_screen,
    input  logic       layer1_enabled,
    input  logic       layer2_enabled,
    input  logic       sprites_enabled,
    input  logic       layer1_done,
    input  logic       layer2_done,
    input  logic       sprites_done,
    output logic       layer1_start,
    output logic       layer2_start,
    output logic       sprites_start,
    output logic [8:0] render_line_idx,
    output logic       lb_wr_bank,
    output logic       busy
);

    localparam logic [8:0] LAST_LINE_IDX = 9'(LAST_LINE);

    state_t     state, state_d;
    logic       enter;
    logic [2:0] en_mask;
    logic [2:0] en_now;
    logic       overrun;
    logic       overrun_sticky;
    logic       sticky_clr;
    logic [7:0] frame_overruns;
    logic [7:0] last_frame_overruns;
    logic [8:0] ovr_sum;
    logic       unused_wrdata;

    // First enabled stage at or after order position from_pos, else DONE.
    function automatic state_t next_stage(input logic [2:0] mask, input int from_pos);
        state_t r;
        r = ST_DONE;
        for (int i = 2; i >= 0; i--) begin
            if (i >= from_pos && mask[i]) r = STAGE_ORDER[i];
        end
        return r;
    endfunction

    assign en_now  = {sprites_enabled, layer2_enabled, layer1_enabled};
    assign busy    = (state == ST_L1) || (state == ST_L2) || (state == ST_SPR);
    assign overrun = display_start_of_line && busy;

    always_comb begin
        state_d = state;
        enter   = 1'b0;
        if (display_start_of_line) begin
            state_d = next_stage(en_now, 0);
            enter   = 1'b1;
        end else begin
            case (state)
                ST_L1:   if (layer1_done)  begin state_d = next_stage(en_mask, 1); enter = 1'b1; end
                ST_L2:   if (layer2_done)  begin state_d = next_stage(en_mask, 2); enter = 1'b1; end
                ST_SPR:  if (sprites_done) begin state_d = ST_DONE;                enter = 1'b1; end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // A restart into the same stage still re-issues its start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer1_start  <= 1'b0;
            layer2_start  <= 1'b0;
            sprites_start <= 1'b0;
        end else begin
            layer1_start  <= enter && (state_d == ST_L1);
            layer2_start  <= enter && (state_d == ST_L2);
            sprites_start <= enter && (state_d == ST_SPR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            render_line_idx <= 9'd0;
            en_mask         <= 3'd0;
            lb_wr_bank      <= 1'b0;
        end else begin
            if (display_start_of_line) begin
                render_line_idx <= (display_line_idx == LAST_LINE_IDX) ? 9'd0 : display_line_idx + 9'd1;
                en_mask         <= en_now;
            end
            if (display_start_of_screen)    lb_wr_bank <= 1'b0;
            else if (display_start_of_line) lb_wr_bank <= ~lb_wr_bank;
        end
    end

    assign sticky_clr = regs_write && (regs_addr == REG_STATUS) && regs_wrdata[7];
    assign unused_wrdata = ^regs_wrdata[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          overrun_sticky <= 1'b0;
        else if (overrun)    overrun_sticky <= 1'b1;
        else if (sticky_clr) overrun_sticky <= 1'b0;
    end

    sat_counter8 u_frame_ovr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (display_start_of_screen),
        .inc   (overrun),
        .count (frame_overruns)
    );

    // Snapshot includes an overrun landing on the frame boundary itself.
    assign ovr_sum = {1'b0, frame_overruns} + {8'd0, overrun};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       last_frame_overruns <= 8'd0;
        else if (display_start_of_screen) last_frame_overruns <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
    end

    always_comb begin
        regs_rddata = 8'd0;
        case (regs_addr)
            REG_STATUS:  regs_rddata = {overrun_sticky, 3'b000, lb_wr_bank, state};
            REG_OVR_CNT: regs_rddata = last_frame_overruns;
            REG_EN_MASK: regs_rddata = {5'b00000, en_mask};
            default:     regs_rddata = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_line_render_sequencer.sv
// tb/tb_line_render_sequencer.sv - directed self-checking bench for line_render_sequencer
module tb_line_render_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] regs_addr = 2'd0;
    logic [7:0] regs_wrdata = 8'd0;
    logic       regs_write = 1'b0;
    logic [7:0] regs_rddata;
    logic [8:0] display_line_idx = 9'd0;
    logic       display_start_of_line = 1'b0;
    logic       display_start_of_screen = 1'b0;
    logic       layer1_enabled = 1'b0;
    logic       layer2_enabled = 1'b0;
    logic       sprites_enabled = 1'b0;
    logic       layer1_done = 1'b0;
    logic       layer2_done = 1'b0;
    logic       sprites_done = 1'b0;
    logic       layer1_start;
    logic       layer2_start;
    logic       sprites_start;
    logic [8:0] render_line_idx;
    logic       lb_wr_bank;
    logic       busy;

    int checks = 0;
    int passes = 0;
    logic [7:0] rdv;

    line_render_sequencer #(.LAST_LINE(479)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .regs_addr               (regs_addr),
        .regs_wrdata             (regs_wrdata),
        .regs_write              (regs_write),
        .regs_rddata             (regs_rddata),
        .display_line_idx        (display_line_idx),
        .display_start_of_line   (display_start_of_line),
        .display_start_of_screen (display_start_of_screen),
        .layer1_enabled          (layer1_enabled),
        .layer2_enabled          (layer2_enabled),
        .sprites_enabled         (sprites_enabled),
        .layer1_done             (layer1_done),
        .layer2_done             (layer2_done),
        .sprites_done            (sprites_done),
        .layer1_start            (layer1_start),
        .layer2_start            (layer2_start),
        .sprites_start           (sprites_start),
        .render_line_idx         (render_line_idx),
        .lb_wr_bank              (lb_wr_bank),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] addr);
        regs_addr = addr;
        #1;
        rdv = regs_rddata;
    endtask

    task automatic set_en(input logic [2:0] m);
        {sprites_enabled, layer2_enabled, layer1_enabled} = m;
    endtask

    task automatic sol_pulse(input logic [8:0] idx);
        display_line_idx = idx;
        display_start_of_line = 1'b1;
        tick();
        display_start_of_line = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_starts", {layer1_start, layer2_start, sprites_start}, 0);
        chk("rst_ridx", render_line_idx, 0);
        chk("rst_bank", lb_wr_bank, 0);
        rd(2'd0); chk("rst_status", rdv, 8'h00);
        rd(2'd1); chk("rst_ovr", rdv, 8'h00);
        rst_n = 1'b1;
        tick();

        // All enabled, line 10, dones 20 cycles after each start
        set_en(3'b111);
        sol_pulse(9'd10);                       // cycle N+1
        chk("t1_l1_start", layer1_start, 1);
        chk("t1_l2_start_n1", layer2_start, 0);
        chk("t1_ridx", render_line_idx, 11);
        chk("t1_bank", lb_wr_bank, 1);
        chk("t1_busy", busy, 1);
        tick();                                 // N+2
        chk("t1_l1_start_n2", layer1_start, 0);
        layer2_done = 1'b1;                     // foreign done in L1 is ignored
        set_en(3'b101);                         // mid-line enable change ignored
        tick();                                 // N+3
        layer2_done = 1'b0;
        chk("t1_foreign_done", layer2_start, 0);
        rd(2'd0); chk("t1_state_l1", rdv[2:0], 3'd1);
        repeat (18) tick();                     // N+21
        layer1_done = 1'b1;
        tick();                                 // N+22
        layer1_done = 1'b0;
        chk("t1_l2_start", layer2_start, 1);
        chk("t1_l1_start_n22", layer1_start, 0);
        repeat (20) tick();                     // N+42
        layer2_done = 1'b1;
        tick();                                 // N+43
        layer2_done = 1'b0;
        chk("t1_spr_start", sprites_start, 1);
        chk("t1_l2_start_n43", layer2_start, 0);
        repeat (20) tick();                     // N+63
        chk("t1_busy_spr", busy, 1);
        sprites_done = 1'b1;
        tick();                                 // N+64
        sprites_done = 1'b0;
        chk("t1_busy_drop", busy, 0);
        rd(2'd0); chk("t1_state_done", rdv[2:0], 3'd4);
        rd(2'd2); chk("t1_mask", rdv, 8'h07);
        tick();
        rd(2'd0); chk("t1_state_idle", rdv[2:0], 3'd0);

        // Only sprites enabled
        set_en(3'b100);
        sol_pulse(9'd20);
        chk("t2_spr_start", sprites_start, 1);
        chk("t2_layer_starts", {layer1_start, layer2_start}, 0);
        chk("t2_bank", lb_wr_bank, 0);
        rd(2'd2); chk("t2_mask", rdv, 8'h04);
        sprites_done = 1'b1;
        tick();
        sprites_done = 1'b0;
        tick();

        // Mask 0 on the last line: wraps to 0, DONE then IDLE with no starts
        set_en(3'b000);
        sol_pulse(9'd479);                      // N+1
        chk("t3_ridx_wrap", render_line_idx, 0);
        chk("t3_no_starts", {layer1_start, layer2_start, sprites_start}, 0);
        chk("t3_busy", busy, 0);
        rd(2'd0); chk("t3_state_done", rdv[2:0], 3'd4);
        tick();                                 // N+2
        rd(2'd0); chk("t3_state_idle", rdv[2:0], 3'd0);
        chk("t3_bank", lb_wr_bank, 1);

        // Overrun during L2 with a coincident done
        set_en(3'b111);
        sol_pulse(9'd30);
        chk("t4_bank0", lb_wr_bank, 0);
        layer1_done = 1'b1;
        tick();
        layer1_done = 1'b0;
        chk("t4_l2_start", layer2_start, 1);
        layer2_done = 1'b1;
        sol_pulse(9'd31);
        layer2_done = 1'b0;
        chk("t4_restart_l1", layer1_start, 1);
        chk("t4_no_spr", sprites_start, 0);
        chk("t4_ridx", render_line_idx, 32);
        rd(2'd0); chk("t4_status", rdv, 8'h89);
        regs_addr = 2'd0; regs_wrdata = 8'h80; regs_write = 1'b1;
        tick();
        regs_write = 1'b0; regs_wrdata = 8'h00;
        rd(2'd0); chk("t4_status_clr", rdv, 8'h09);

        // Frame boundary snapshot of one overrun
        display_start_of_screen = 1'b1;
        tick();
        display_start_of_screen = 1'b0;
        rd(2'd1); chk("t5_ovr_one", rdv, 8'd1);
        chk("t5_bank", lb_wr_bank, 0);

        // 301 back-to-back overruns saturate at 255
        display_start_of_line = 1'b1;
        repeat (301) tick();
        display_start_of_line = 1'b0;
        chk("t6_bank_pre", lb_wr_bank, 1);
        rd(2'd0); chk("t6_sticky", rdv[7], 1);
        display_start_of_screen = 1'b1;
        tick();
        display_start_of_screen = 1'b0;
        rd(2'd1); chk("t6_ovr_sat", rdv, 8'd255);
        chk("t6_bank_sos", lb_wr_bank, 0);

        // Coincident start_of_screen and overrunning start_of_line
        display_start_of_screen = 1'b1;
        sol_pulse(9'd0);
        display_start_of_screen = 1'b0;
        rd(2'd1); chk("t7_ovr_coinc", rdv, 8'd1);
        chk("t7_bank_prio", lb_wr_bank, 0);
        chk("t7_l1_start", layer1_start, 1);

        // Async reset during SPR
        layer1_done = 1'b1; tick(); layer1_done = 1'b0;
        layer2_done = 1'b1; tick(); layer2_done = 1'b0;
        chk("t8_spr_start", sprites_start, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t8_rst_spr", sprites_start, 0);
        chk("t8_rst_busy", busy, 0);
        chk("t8_rst_ridx", render_line_idx, 0);
        chk("t8_rst_bank", lb_wr_bank, 0);
        rd(2'd0); chk("t8_rst_status", rdv, 8'h00);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            {layer1_done, layer2_done, sprites_done} = 3'b111;
            tick();
            chk("t8_no_start", {layer1_start, layer2_start, sprites_start}, 0);
        end
        {layer1_done, layer2_done, sprites_done} = 3'b000;
        sol_pulse(9'd100);
        chk("t8_l1_after", layer1_start, 1);
        chk("t8_ridx_after", render_line_idx, 101);
        chk("t8_bank_after", lb_wr_bank, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/line_render_sequencer.md
# line_render_sequencer

Sequences per-line rendering of layer 1, layer 2 and sprites ahead of the display composer. The three renderers share VRAM fetch bandwidth, so they must run one after another within each line period. The block issues their start pulses in a fixed order, skips disabled renderers and selects the ping-pong line-buffer bank. It also detects lines whose rendering did not finish before the next line started and reports them through a small register window.

## Interface
- `LAST_LINE`, 479: last line index before `render_line_idx` wraps to 0.
- `clk` in 1: pixel/system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `regs_addr` in 2: register select.
- `regs_wrdata` in 8: register write data.
- `regs_write` in 1: register write strobe.
- `regs_rddata` out 8: combinational read data.
- `display_line_idx` in 9: line currently being displayed.
- `display_start_of_line` in 1: one-cycle pulse at the start of each line.
- `display_start_of_screen` in 1: one-cycle pulse at the start of each frame.
- `layer1_enabled`, `layer2_enabled`, `sprites_enabled` in 1 each: renderer enables.
- `layer1_done`, `layer2_done`, `sprites_done` in 1 each: one-cycle completion pulses.
- `layer1_start`, `layer2_start`, `sprites_start` out 1 each: one-cycle registered start pulses.
- `render_line_idx` out 9: line being rendered.
- `lb_wr_bank` out 1: bank the renderers write; the composer reads `~lb_wr_bank`.
- `busy` out 1: a render sequence is in progress.

## Operation
- States: IDLE, L1, L2, SPR, DONE (3-bit encoding).
- On `display_start_of_line`:
  - `render_line_idx` <= `display_line_idx == LAST_LINE ? 0 : display_line_idx + 1` (9-bit).
  - `lb_wr_bank` toggles.
  - Enables are latched into a 3-bit mask. Enable changes mid-line are ignored.
  - The state moves to the first enabled stage in order L1 → L2 → SPR, or to DONE if the mask is 0.
- Entering L1, L2 or SPR pulses the matching `*_start` for exactly one cycle.
- In a stage, that stage's `*_done` advances the state to the next enabled stage, or to DONE. `done` inputs from other stages are ignored.
- DONE → IDLE on the next cycle. `busy` = state ∈ {L1, L2, SPR}.
- Overrun: `display_start_of_line` arrives while `busy`.
  - The current stage is abandoned and the sequence restarts for the new line as above.
  - `overrun_sticky` is set.
  - `frame_overruns` increments, saturating at 255.
  - Renderers accept a new start without a prior done.
- `display_start_of_screen`:
  - `last_frame_overruns` <= `frame_overruns` + (overrun detected this same cycle).
  - `frame_overruns` <= 0.
  - `lb_wr_bank` <= 0. This takes priority over a toggle from a coincident start_of_line.
- Registers:
  - Address 0 (status), read: {`overrun_sticky`, 3'b0, `lb_wr_bank`, state[2:0]}. Writing bit7 = 1 clears `overrun_sticky`. A coincident set wins over the clear.
  - Address 1: `last_frame_overruns`, read-only.
  - Address 2: {5'b0, latched enable mask}, read-only.
  - Address 3: reads 0.

## Timing
- Reset (async, `rst_n` low):
  - state IDLE.
  - All `*_start` 0.
  - `busy` 0.
  - `render_line_idx` 0.
  - `lb_wr_bank` 0.
  - Sticky flag and both counters 0.
- `*_start` asserts on the cycle after `display_start_of_line` (cycle N+1).
- A `done` on cycle M gives the next stage's start on cycle M+1. There is no back-to-back gap beyond that.
- Skipped stages cost 0 cycles.
- `render_line_idx` and `lb_wr_bank` are valid from cycle N+1. They stay stable until the next start_of_line.
- A `done` coincident with `display_start_of_line` is treated as an overrun; restart wins.
- Reset deasserted mid-line: the block stays IDLE until the next `display_start_of_line`.

## Structure
- Shared package:
  - state encoding constants.
  - register addresses (`REG_STATUS`=0, `REG_OVR_CNT`=1, `REG_EN_MASK`=2).
  - the stage-order constant.
- Sub-module `sat_counter8`: 8-bit saturating counter with synchronous clear and increment.
- The stage-selection "next enabled stage" function is combinational, local to the module.

## Test plan
- All enabled, `display_line_idx`=10, each done 20 cycles after its start:
  - starts at N+1, N+22, N+43.
  - `render_line_idx`=11.
  - bank toggles 0→1.
  - `busy` drops the cycle after `sprites_done`.
- Only sprites enabled: `sprites_start` at N+1, no layer starts. Mask 0: no starts, state IDLE at N+2.
- `display_line_idx`=479: `render_line_idx`=0.
- Start_of_line during L2:
  - `overrun_sticky`=1.
  - register 0 bit7=1.
  - `layer1_start` at next N+1.
  - write 0x80 to address 0 clears the flag.
- 300 overruns in one frame, then start_of_screen:
  - register 1 reads 255.
  - `lb_wr_bank`=0.
- Assert `rst_n` low during SPR:
  - all outputs go to reset values immediately.
  - no start pulses until the next start_of_line.
